rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
// - Shares the two read ports (A, B) of a dual-port synchronous ROM among NUM_REQ requesters.
// - Typical client: the SMVM engines fetching matrix/vector words from romB_128x1.
// - Grants up to two requesters per cycle, round-robin.
// - Issues their addresses to the ROM ports and routes each q word back to its owner after ROM_LAT cycles.
// PARAMETERS
// - NUM_REQ  4  number of requesters (2..8)
// - ADDR_W   7  ROM address width
// - DATA_W   8  ROM data width
// - ROM_LAT  2  clocks from address presented at rom_addr_* to valid data on rom_q_* (>=1)
// PORTS
// - clk        in   1                clock, all logic on posedge
// - rst        in   1                synchronous reset, active-high
// - req_valid  in   NUM_REQ          requester i has a read pending
// - req_addr   in   NUM_REQ*ADDR_W   address of requester i, slice [i*ADDR_W +: ADDR_W]
// - req_ready  out  NUM_REQ          grant; read of requester i accepted this cycle
// - rom_addr_a out  ADDR_W           ROM port A address (to address_a)
// - rom_addr_b out  ADDR_W           ROM port B address (to address_b)
// - rom_q_a    in   DATA_W           ROM port A data (from q_a)
// - rom_q_b    in   DATA_W           ROM port B data (from q_b)
// - rsp_valid  out  NUM_REQ          response for requester i valid this cycle (1-cycle pulse)
// - rsp_data   out  NUM_REQ*DATA_W   response data, slice [i*DATA_W +: DATA_W]
// BEHAVIOUR
// - Handshake: a read transfers when req_valid[i] && req_ready[i] in the same cycle.
//   - req_ready is combinational from req_valid and the rr pointer.
//   - Requester holds valid/addr stable until ready.
// - Grant, each cycle:
//   - Port A goes to the first valid requester at index >= ptr (cyclic).
//   - Port B goes to the next valid requester after A's grantee (cyclic, excluding A's grantee).
//   - No second requester -> port B idle.
// - At most one grant per requester per cycle; at most 2 grants per cycle total.
// - rr pointer ptr (reset 0), updated on posedge:
//   - Two grants: ptr <= (B grantee + 1) mod NUM_REQ.
//   - One grant: ptr <= (A grantee + 1) mod NUM_REQ.
//   - No grants: ptr unchanged.
// - rom_addr_a/b are combinational: granted address, or 0 when that port is idle or rst=1.
// - Same address on both ports is legal; no conflict handling.
// - Tracking: each port has a ROM_LAT-deep shift register of {valid, requester id}.
//   - Stage 0 loads the grant; data is sampled when the entry exits at ROM_LAT.
// - Response:
//   - rsp_valid[i] and rsp_data slice i are combinational from the exiting entry and rom_q_a/b.
//   - Port A and port B never target the same requester in the same cycle (fixed latency, one grant per cycle).
//   - rsp_data slice for a non-responding requester is 0.
// - Latency: grant at cycle t -> rsp_valid at cycle t+ROM_LAT. No backpressure on responses; the requester must accept.
// - Throughput: 2 reads/cycle sustained when >=2 requesters are valid.
// - Reset values: req_ready=0, rom_addr_a/b=0, rsp_valid=0, rsp_data=0, ptr=0, all pipeline valids=0.
// - Reset mid-operation:
//   - All in-flight reads are dropped.
//   - No rsp_valid is produced for reads granted before or during rst.
//   - First grant is possible in the first cycle after rst deasserts.
// - Single requester repeatedly valid: granted every cycle on port A only.
// - req_valid deasserted without ready: legal; no grant, no state change.
// TESTING (behavioural ROM model: ROM_LAT=2, q = addr ^ 8'hA5)
// - Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rom_addr_a/b=0 throughout.
// - Single requester: req 2, addr 7'h10 at cycle t -> ready[2]=1 at t, rom_addr_a=7'h10, rom_addr_b=0; rsp_valid[2]=1 with data 8'hB5 at t+2 only.
// - All 4 valid for 4 cycles, ptr=0 -> grants {0,1},{2,3},{0,1},{2,3}; each requester gets 2 responses, correct data, in order.
// - Requesters 1 and 3 valid, ptr=2 -> A=3, B=1; next ptr=2; addrs 7'h7F/7'h00 -> data 8'hDA/8'hA5.
// - Reset mid-flight: grant at t, rst=1 at t+1 -> no rsp_valid at t+2; a new grant after rst returns normally at +2.
// - Random: 2000 cycles of random valid/addr against a scoreboard -> every accepted read answered exactly once at +2.
//   - No starvation: a held request is granted within ceil(NUM_REQ/2) cycles.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the two read ports of a dual-port synchronous ROM
// among NUM_REQ requesters; returns each q word to its owner ROM_LAT cycles later.
module rom_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr_a,
  output logic [ADDR_W-1:0]         rom_addr_b,
  input  logic [DATA_W-1:0]         rom_q_a,
  input  logic [DATA_W-1:0]         rom_q_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [ID_W-1:0] id_t;

  function automatic id_t wrap_inc(input id_t id, input int step);
    return id_t'((int'(id) + step) % NUM_REQ);
  endfunction

  id_t ptr, ptr_nxt;
  id_t idx;
  logic gnt_a, gnt_b;
  id_t  id_a, id_b;

  logic [ROM_LAT-1:0] vld_a, vld_b;
  id_t                pid_a [ROM_LAT];
  id_t                pid_b [ROM_LAT];

  // Scan cyclically from ptr: first valid requester takes port A, the next one port B.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    id_a  = '0;
    id_b  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // NOTE: blocking assignments here; idx is a scratch value rewritten each iteration.
      idx = wrap_inc(ptr, k);
      if (!rst && req_valid[idx]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          id_a  = idx;
        end else if (!gnt_b) begin
          gnt_b = 1'b1;
          id_b  = idx;
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (gnt_b)      ptr_nxt = wrap_inc(id_b, 1);
    else if (gnt_a) ptr_nxt = wrap_inc(id_a, 1);
  end

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[id_a] = 1'b1;
    if (gnt_b) req_ready[id_b] = 1'b1;
  end

  assign rom_addr_a = gnt_a ? req_addr[id_a*ADDR_W +: ADDR_W] : '0;
  assign rom_addr_b = gnt_b ? req_addr[id_b*ADDR_W +: ADDR_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      vld_a <= '0;
      vld_b <= '0;
    end else begin
      ptr      <= ptr_nxt;
      vld_a[0] <= gnt_a;
      vld_b[0] <= gnt_b;
      for (int s = 1; s < ROM_LAT; s++) begin
        vld_a[s] <= vld_a[s-1];
        vld_b[s] <= vld_b[s-1];
      end
    end
  end

  // NOTE: requester ids carry no reset; they only matter when the matching valid bit is set.
  always_ff @(posedge clk) begin
    pid_a[0] <= id_a;
    pid_b[0] <= id_b;
    for (int s = 1; s < ROM_LAT; s++) begin
      pid_a[s] <= pid_a[s-1];
      pid_b[s] <= pid_b[s-1];
    end
  end

  // Exiting entries steer the ROM words; ports never target the same requester together.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!rst && vld_a[ROM_LAT-1]) begin
      rsp_valid[pid_a[ROM_LAT-1]] = 1'b1;
      rsp_data[pid_a[ROM_LAT-1]*DATA_W +: DATA_W] = rom_q_a;
    end
    if (!rst && vld_b[ROM_LAT-1]) begin
      rsp_valid[pid_b[ROM_LAT-1]] = 1'b1;
      rsp_data[pid_b[ROM_LAT-1]*DATA_W +: DATA_W] = rom_q_b;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a 2-cycle ROM model (q = addr ^ 8'hA5)
// and a per-requester scoreboard of expected responses.
module tb_rom_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr_a, rom_addr_b;
  logic [DW-1:0]   rom_q_a, rom_q_b;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;

  rom_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous ROM model
  logic [AW-1:0] a_d, b_d;
  always @(posedge clk) begin
    a_d     <= rom_addr_a;
    b_d     <= rom_addr_b;
    rom_q_a <= {1'b0, a_d} ^ 8'hA5;
    rom_q_b <= {1'b0, b_d} ^ 8'hA5;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [7:0]  data;
  } ent_t;

  ent_t sb [N][$];
  int   rsp_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_of(input logic [AW-1:0] a);
    return {1'b0, a} ^ 8'hA5;
  endfunction

  // Scoreboard: pop on response, push on accepted read, flush on reset
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sb[i].delete();
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          total++;
          assert (sb[i].size() != 0) else begin
            bad++;
            $error("FAIL rsp_unexpected req=%0d observed=valid expected=idle", i);
          end
          if (sb[i].size() != 0) begin
            ent_t e;
            e = sb[i].pop_front();
            rsp_cnt[i]++;
            check($sformatf("rsp_data_r%0d", i), 32'(rsp_data[i*DW +: DW]), 32'(e.data));
            check($sformatf("rsp_time_r%0d", i), 32'(cyc), 32'(e.due));
          end
        end else begin
          check($sformatf("rsp_idle_data_r%0d", i), 32'(rsp_data[i*DW +: DW]), 32'h0);
          if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
            total++;
            bad++;
            $error("FAIL rsp_missing req=%0d observed=idle expected=valid at cycle %0d", i, sb[i][0].due);
            void'(sb[i].pop_front());
          end
        end
        if (req_valid[i] && req_ready[i]) begin
          ent_t e;
          e.due  = cyc + 2;
          e.data = rom_of(req_addr[i*AW +: AW]);
          sb[i].push_back(e);
        end
      end
    end
  end

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Address used by requester i in burst cycle c: bumps after each grant
  function automatic logic [AW-1:0] burst_addr(input int i, input int c);
    int n;
    n = (i < 2) ? (c + 1) / 2 : c / 2;
    return AW'(16 * i + n);
  endfunction

  int          snap [N];
  logic [N-1:0] pend;
  int          age [N];

  initial begin
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    rst       = 1'b1;
    req_valid = '1;
    req_addr  = {7'h11, 7'h22, 7'h33, 7'h44};

    // Reset held three cycles with every requester valid
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_rsp", 32'(rsp_valid), 32'h0);
      check("rst_addr_a", 32'(rom_addr_a), 32'h0);
      check("rst_addr_b", 32'(rom_addr_b), 32'h0);
      next_cycle();
    end
    rst       = 1'b0;
    req_valid = '0;

    // Single requester 2
    req_valid = 4'b0100;
    set_addr(2, 7'h10);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_addr_a", 32'(rom_addr_a), 32'h10);
    check("single_addr_b", 32'(rom_addr_b), 32'h0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("single_rsp_t1", 32'(rsp_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("single_rsp_t2", 32'(rsp_valid), 32'h4);
    check("single_data", 32'(rsp_data[2*DW +: DW]), 32'hB5);
    next_cycle();
    @(negedge clk);
    check("single_rsp_t3", 32'(rsp_valid), 32'h0);
    next_cycle();

    // Requester 3 alone brings ptr back to 0
    req_valid = 4'b1000;
    set_addr(3, 7'h01);
    @(negedge clk);
    check("wrap_ready", 32'(req_ready), 32'h8);
    next_cycle();
    req_valid = '0;
    for (int c = 0; c < 3; c++) next_cycle();

    // All four valid for four cycles
    for (int i = 0; i < N; i++) snap[i] = rsp_cnt[i];
    for (int c = 0; c < 4; c++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) set_addr(i, burst_addr(i, c));
      @(negedge clk);
      check($sformatf("all_ready_c%0d", c), 32'(req_ready), (c % 2 == 1) ? 32'hC : 32'h3);
      check($sformatf("all_addr_a_c%0d", c), 32'(rom_addr_a), 32'(burst_addr((c % 2 == 1) ? 2 : 0, c)));
      check($sformatf("all_addr_b_c%0d", c), 32'(rom_addr_b), 32'(burst_addr((c % 2 == 1) ? 3 : 1, c)));
      next_cycle();
    end
    req_valid = '0;
    for (int c = 0; c < 3; c++) next_cycle();
    for (int i = 0; i < N; i++)
      check($sformatf("all_rsp_count_r%0d", i), 32'(rsp_cnt[i] - snap[i]), 32'd2);

    // Requester 1 alone sets ptr=2, then 1 and 3 compete
    req_valid = 4'b0010;
    set_addr(1, 7'h05);
    @(negedge clk);
    check("ptr2_ready", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 4'b1010;
    set_addr(1, 7'h00);
    set_addr(3, 7'h7F);
    @(negedge clk);
    check("pair_ready", 32'(req_ready), 32'hA);
    check("pair_addr_a", 32'(rom_addr_a), 32'h7F);
    check("pair_addr_b", 32'(rom_addr_b), 32'h00);
    next_cycle();
    req_valid = 4'b1111;
    set_addr(0, 7'h40);
    set_addr(2, 7'h42);
    @(negedge clk);
    check("pair_ptr_kept", 32'(req_ready), 32'hC);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("pair_rsp", 32'(rsp_valid), 32'hA);
    check("pair_data3", 32'(rsp_data[3*DW +: DW]), 32'hDA);
    check("pair_data1", 32'(rsp_data[1*DW +: DW]), 32'hA5);
    next_cycle();
    next_cycle();

    // Reset while a read is in flight
    req_valid = 4'b0001;
    set_addr(0, 7'h22);
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'h1);
    next_cycle();
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("midrst_rsp_in_rst", 32'(rsp_valid), 32'h0);
    next_cycle();
    rst       = 1'b0;
    req_valid = 4'b0100;
    set_addr(2, 7'h33);
    @(negedge clk);
    check("midrst_dropped", 32'(rsp_valid), 32'h0);
    check("midrst_first_grant", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    check("midrst_new_rsp", 32'(rsp_valid), 32'h4);
    check("midrst_new_data", 32'(rsp_data[2*DW +: DW]), 32'h96);
    next_cycle();

    // Random traffic; pending requests are held until granted
    pend = '0;
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int r = 0; r < 2000; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_addr(i, AW'($urandom_range(0, 127)));
        end
      end
      @(negedge clk);
      check("rnd_grant_count_ok", 32'($countones(req_ready) <= 2), 32'h1);
      check("rnd_ready_subset", 32'(req_ready & ~req_valid), 32'h0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i]) begin
            check($sformatf("rnd_starve_r%0d", i), 32'(age[i] <= 1), 32'h1);
            age[i]  = 0;
            pend[i] = 1'b0;
          end else begin
            age[i]++;
            pend[i] = 1'b1;
          end
        end
      end
      next_cycle();
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) next_cycle();
    for (int i = 0; i < N; i++)
      check($sformatf("drain_empty_r%0d", i), 32'(sb[i].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
